// File: rtl/nand_chk_pkg.sv
// Shared types and helpers for the NAND response checker: FSM states,
// number of input combinations and the reference NAND function.
package nand_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NAND_COMBOS = 4;

  function automatic logic nand_expect(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_chk_cmp.sv
// Combinational judge for one sampled vector: mismatch flag against the NAND
// reference and a one-hot coverage hit for the {a,b} pair (zero when COVER_EN=0).
module nand_chk_cmp
  import nand_chk_pkg::*;
#(
  parameter bit COVER_EN = 1'b0
) (
  input  logic                   i_a,
  input  logic                   i_b,
  input  logic                   i_y,
  output logic                   o_mismatch,
  output logic [NAND_COMBOS-1:0] o_cov_hit
);

  logic [1:0] w_idx;

  assign w_idx      = {i_a, i_b};
  assign o_mismatch = (i_y != nand_expect(i_a, i_b));

  always_comb begin
    o_cov_hit = '0;
    if (COVER_EN) o_cov_hit[w_idx] = 1'b1;
  end

endmodule

// File: rtl/nand_resp_checker.sv
// NAND gate response checker: accepts {a,b,y} vectors, counts vectors and
// errors, captures the first failure. Coverage tracking when NAND_CHK_COVER_EN is defined.
//
// Handshake: a vector transfers on a rising clk edge where in_valid && in_ready;
// in_ready is high only in CHECK, and in_valid has no effect in IDLE or DONE.
module nand_resp_checker
  import nand_chk_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec,
  output logic [3:0]       coverage,
  output logic [1:0]       o_dbg_state
);

  localparam logic [CNT_W-1:0] LP_NUM     = CNT_W'(NUM_VEC);
  localparam logic [ERR_W-1:0] LP_ERR_MAX = '1;
`ifdef NAND_CHK_COVER_EN
  localparam bit LP_COVER_EN = 1'b1;
`else
  localparam bit LP_COVER_EN = 1'b0;
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_ff_idx;
  logic [2:0]       r_ff_vec;
  logic [3:0]       r_cov;

  logic             w_accept;
  logic             w_start_ok;
  logic             w_last;
  logic             w_mismatch;
  logic [3:0]       w_cov_hit;
  logic [3:0]       w_cov_nxt;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_pass_nxt;

  nand_chk_cmp #(
    .COVER_EN (LP_COVER_EN)
  ) u_cmp (
    .i_a        (in_a),
    .i_b        (in_b),
    .i_y        (in_y),
    .o_mismatch (w_mismatch),
    .o_cov_hit  (w_cov_hit)
  );

  assign w_accept   = in_valid && (r_state == CHECK);
  assign w_start_ok = start && (r_state != CHECK);
  assign w_last     = w_accept && ((r_vec_cnt + 1'b1) == LP_NUM);
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != LP_ERR_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;
  assign w_cov_nxt  = r_cov | w_cov_hit;

`ifdef NAND_CHK_COVER_EN
  assign w_pass_nxt = (w_err_nxt == '0) && (w_cov_nxt == 4'b1111);
`else
  assign w_pass_nxt = (w_err_nxt == '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = (NUM_VEC == 0) ? DONE : CHECK;
      CHECK:      if (w_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_vec_cnt <= '0;
      r_err_cnt <= '0;
      r_ff_idx  <= '0;
      r_ff_vec  <= '0;
      r_cov     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == DONE);
      if (w_start_ok) begin
        r_vec_cnt <= '0;
        r_err_cnt <= '0;
        r_ff_idx  <= '0;
        r_ff_vec  <= '0;
        r_cov     <= '0;
        // An empty run finishes immediately with no errors and no coverage.
        r_pass    <= (NUM_VEC == 0) && !LP_COVER_EN;
      end else if (w_accept) begin
        r_vec_cnt <= r_vec_cnt + 1'b1;
        r_err_cnt <= w_err_nxt;
        r_cov     <= w_cov_nxt;
        r_pass    <= w_last && w_pass_nxt;
        if (w_mismatch && (r_err_cnt == '0)) begin
          r_ff_idx <= r_vec_cnt;
          r_ff_vec <= {in_a, in_b, in_y};
        end
      end
    end
  end

  assign in_ready       = (r_state == CHECK);
  assign busy           = (r_state == CHECK);
  assign done           = r_done;
  assign pass           = r_pass;
  assign vec_cnt        = r_vec_cnt;
  assign err_cnt        = r_err_cnt;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_vec = r_ff_vec;
  assign coverage       = r_cov;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_nand_resp_checker.sv
// Directed bench for nand_resp_checker: default instance (NUM_VEC=4) and a
// saturation instance (NUM_VEC=6, ERR_W=2); results checked from an expected queue.
module tb_nand_resp_checker;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst, start, in_valid, in_a, in_b, in_y;
  logic       in_ready, busy, done, pass;
  logic [7:0] vec_cnt, err_cnt, ffi;
  logic [2:0] ffv;
  logic [3:0] cov;
  logic [1:0] dbg;

  // saturation instance
  logic       s_rst, s_start, s_in_valid, s_in_a, s_in_b, s_in_y;
  logic       s_in_ready, s_busy, s_done, s_pass;
  logic [7:0] s_vec_cnt, s_ffi;
  logic [1:0] s_err_cnt;
  logic [2:0] s_ffv;
  logic [3:0] s_cov;
  logic [1:0] s_dbg;

  nand_resp_checker u_dut (
    .clk (clk), .rst (rst), .start (start), .in_valid (in_valid), .in_ready (in_ready),
    .in_a (in_a), .in_b (in_b), .in_y (in_y), .busy (busy), .done (done), .pass (pass),
    .vec_cnt (vec_cnt), .err_cnt (err_cnt), .first_fail_idx (ffi), .first_fail_vec (ffv),
    .coverage (cov), .o_dbg_state (dbg)
  );

  nand_resp_checker #(.NUM_VEC(6), .CNT_W(8), .ERR_W(2)) u_dut_sat (
    .clk (clk), .rst (s_rst), .start (s_start), .in_valid (s_in_valid), .in_ready (s_in_ready),
    .in_a (s_in_a), .in_b (s_in_b), .in_y (s_in_y), .busy (s_busy), .done (s_done), .pass (s_pass),
    .vec_cnt (s_vec_cnt), .err_cnt (s_err_cnt), .first_fail_idx (s_ffi), .first_fail_vec (s_ffv),
    .coverage (s_cov), .o_dbg_state (s_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // reference model state for the run in progress
  int         m_vec, m_err, m_ffi, m_num, m_max;
  logic [2:0] m_ffv;
  logic [3:0] m_cov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int num, input int max_err);
    m_vec = 0; m_err = 0; m_ffi = 0; m_ffv = '0; m_cov = '0;
    m_num = num; m_max = max_err;
  endtask

  function automatic logic [W-1:0] model_pack();
    logic       e_pass;
    logic [3:0] e_cov;
`ifdef NAND_CHK_COVER_EN
    e_cov  = m_cov;
    e_pass = (m_err == 0) && (m_cov == 4'b1111);
`else
    e_cov  = 4'b0000;
    e_pass = (m_err == 0);
`endif
    return {e_pass, e_cov, m_ffv, m_ffi[7:0], m_err[7:0], m_vec[7:0]};
  endfunction

  // Drive one vector (optionally with start) at a negedge, let it be accepted,
  // then advance the model; the final vector of a run pushes the expected result.
  task automatic send(input bit sel, input logic a, input logic b, input logic y, input logic st);
    logic e_y;
    if (sel) begin
      s_in_valid = 1'b1; s_in_a = a; s_in_b = b; s_in_y = y; s_start = st;
    end else begin
      in_valid = 1'b1; in_a = a; in_b = b; in_y = y; start = st;
    end
    @(negedge clk);
    start = 1'b0; s_start = 1'b0;
    e_y = ~(a & b);
    if (y !== e_y) begin
      if (m_err == 0) begin
        m_ffi = m_vec;
        m_ffv = {a, b, y};
      end
      if (m_err < m_max) m_err++;
    end
    m_cov[{a, b}] = 1'b1;
    m_vec++;
    if (m_vec == m_num) exp_q.push_back(model_pack());
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; s_in_valid = 1'b0; start = 1'b0; s_start = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) s_start = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_start = 1'b0;
  endtask

  // done must already be high right after the final accept edge
  task automatic wait_done(input bit sel, input string tag);
    int lat = 0;
    logic [W-1:0] obs, exp;
    while (((sel ? s_done : done) !== 1'b1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_lat"}, lat, 0);
    check({tag, "_q_size"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      obs = sel ? {s_pass, s_cov, s_ffv, s_ffi, 6'b0, s_err_cnt, s_vec_cnt}
                : {pass, cov, ffv, ffi, err_cnt, vec_cnt};
      check({tag, "_vec_cnt"}, obs[7:0],   exp[7:0]);
      check({tag, "_err_cnt"}, obs[15:8],  exp[15:8]);
      check({tag, "_ff_idx"},  obs[23:16], exp[23:16]);
      check({tag, "_ff_vec"},  obs[26:24], exp[26:24]);
      check({tag, "_cov"},     obs[30:27], exp[30:27]);
      check({tag, "_pass"},    obs[31],    exp[31]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // clock/reset
    idle_inputs();
    in_a = 1'b0; in_b = 1'b0; in_y = 1'b0;
    s_in_a = 1'b0; s_in_b = 1'b0; s_in_y = 1'b0;
    rst = 1'b1; s_rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;

    check("rst_state",    dbg, 2'd0);
    check("rst_busy",     busy, 1'b0);
    check("rst_ready",    in_ready, 1'b0);
    check("rst_done",     done, 1'b0);
    check("rst_pass",     pass, 1'b0);
    check("rst_vec_cnt",  vec_cnt, 8'd0);
    check("rst_err_cnt",  err_cnt, 8'd0);
    check("rst_ff",       {ffi, ffv}, 11'd0);
    check("rst_cov",      cov, 4'd0);

    // in_valid while IDLE is ignored
    in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_y = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready",   in_ready, 1'b0);
    check("idle_vec_cnt", vec_cnt, 8'd0);
    check("idle_state",   dbg, 2'd0);
    in_valid = 1'b0;

    // run 1: good gate, all four combinations
    model_clear(4, 255);
    pulse_start(0);
    check("r1_busy",  busy, 1'b1);
    check("r1_ready", in_ready, 1'b1);
    check("r1_state", dbg, 2'd1);
    send(0, 0, 0, 1, 0);
    send(0, 0, 1, 1, 0);
    send(0, 1, 0, 1, 0);
    send(0, 1, 1, 0, 0);
    idle_inputs();
    wait_done(0, "r1");
    check("r1_done_state", dbg, 2'd2);
    check("r1_done_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("r1_hold_vec", vec_cnt, 8'd4);
    check("r1_hold_done", done, 1'b1);

    // run 2: restart from DONE, third vector faulty
    model_clear(4, 255);
    pulse_start(0);
    check("r2_clear", {vec_cnt, err_cnt, cov, done, pass}, 22'd0);
    send(0, 0, 0, 1, 0);
    send(0, 0, 1, 1, 0);
    send(0, 1, 1, 1, 0);
    send(0, 1, 0, 1, 0);
    idle_inputs();
    wait_done(0, "r2");

    // run 3: start pulses during CHECK are ignored
    model_clear(4, 255);
    pulse_start(0);
    send(0, 0, 0, 1, 0);
    send(0, 0, 1, 1, 1);
    check("r3_no_restart_vec", vec_cnt, 8'd2);
    check("r3_no_restart_busy", busy, 1'b1);
    send(0, 1, 0, 1, 0);
    send(0, 1, 1, 0, 1);
    idle_inputs();
    wait_done(0, "r3");
    @(negedge clk);
    check("r3_still_done", dbg, 2'd2);

    // run 4: reset after two accepts discards the partial run
    model_clear(4, 255);
    pulse_start(0);
    send(0, 1, 1, 1, 0);
    send(0, 0, 1, 1, 0);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r4_rst_state", dbg, 2'd0);
    check("r4_rst_cnts",  {vec_cnt, err_cnt, ffi, ffv, cov}, 31'd0);
    check("r4_rst_flags", {done, busy, pass}, 3'd0);

    // run 5: after reset, four 00/1 vectors only
    model_clear(4, 255);
    pulse_start(0);
    repeat (4) send(0, 0, 0, 1, 0);
    idle_inputs();
    wait_done(0, "r5");

    // saturating error counter: six faulty vectors with ERR_W=2
    model_clear(6, 3);
    pulse_start(1);
    send(1, 1, 1, 1, 0);
    send(1, 0, 0, 0, 0);
    send(1, 0, 1, 0, 0);
    check("sat_err_at3", s_err_cnt, 2'd3);
    send(1, 1, 0, 0, 0);
    send(1, 1, 1, 1, 0);
    check("sat_err_held", s_err_cnt, 2'd3);
    check("sat_not_done", s_done, 1'b0);
    send(1, 0, 0, 0, 0);
    idle_inputs();
    wait_done(1, "sat");

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_resp_checker.md
Name: nand_resp_checker

Overview:
- Response-side partner of the NAND gate stimulus fixture. Stimulus driving stays in the fixture; this block receives and judges the results.
- Accepts sampled (a, b, y) vectors from the gate under test over a valid/ready handshake.
- Checks each vector against y == ~(a & b), then counts vectors and errors, captures the first failure, and reports pass/done.
- Synthesizable; can be used as an on-chip self-test monitor or inside benches.

Parameters:
- NUM_VEC, 4, number of vectors per run; 0 allowed; must be < 2**CNT_W.
- CNT_W, 8, width of vec_cnt and first_fail_idx.
- ERR_W, 8, width of err_cnt; saturating.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- in_valid  in  1  vector on in_a/in_b/in_y is valid.
- in_ready  out  1  block accepts a vector; 1 only in CHECK.
- in_a  in  1  sampled gate input a.
- in_b  in  1  sampled gate input b.
- in_y  in  1  sampled gate output y.
- busy  out  1  state == CHECK.
- done  out  1  state == DONE.
- pass  out  1  valid only when done.
- vec_cnt  out  CNT_W  vectors accepted in the current run.
- err_cnt  out  ERR_W  mismatches in the current run, saturating.
- first_fail_idx  out  CNT_W  vec_cnt value at the first mismatch.
- first_fail_vec  out  3  {a, b, y} of the first mismatch.
- coverage  out  4  bit {a,b} set once that input pair has been seen.

Behaviour:
- One clock. Reset is synchronous, active-high. All outputs are registered except in_ready and busy, which decode the state register.
- Reset values: state=IDLE; every counter, capture register, coverage, done, busy, pass and in_ready = 0.
- Handshake: a vector is accepted on a rising edge where in_valid && in_ready. in_valid in IDLE or DONE is ignored and no vector is consumed.
- IDLE: on start, go to CHECK and clear vec_cnt, err_cnt, first_fail_*, and coverage.
  - If NUM_VEC==0, go directly to DONE instead.
- CHECK, on each accepted vector:
  - vec_cnt increments.
  - A mismatch increments err_cnt, saturating at 2**ERR_W-1.
  - On the first mismatch (err_cnt==0 before the update), capture first_fail_idx = the pre-increment vec_cnt and first_fail_vec = {a, b, y}.
  - coverage[{a,b}] is set.
- The accept that brings vec_cnt to NUM_VEC moves the state to DONE. done asserts the next cycle; counters are already final in that cycle.
- start during CHECK is ignored, including in the cycle of the last accept.
- DONE: in_ready=0 and all results hold.
  - pass = (err_cnt==0) plus the coverage term (see Optional Feature).
  - start clears results and re-enters CHECK, or DONE again if NUM_VEC==0.
- Reset mid-run aborts immediately to the reset values; a partial run is discarded.
- Width rules:
  - The compare is 1-bit exact.
  - vec_cnt never wraps, because NUM_VEC < 2**CNT_W.
  - err_cnt saturates and never wraps.

Optional Feature:
- Macro: NAND_CHK_COVER_EN.
- Defined: coverage is tracked as described, and pass = done && err_cnt==0 && coverage==4'b1111.
- Undefined: coverage is driven 4'b0000, and pass = done && err_cnt==0.

Decomposition:
- Package nand_chk_pkg:
  - state enum IDLE/CHECK/DONE;
  - constant NAND_COMBOS=4;
  - function nand_expect(a, b) returning ~(a&b).
- One sub-module, nand_chk_cmp: combinational mismatch flag plus coverage index decode. The FSM and counters stay in the top module.

Test Plan:
- Default parameters, NUM_VEC=4. rst, then start, then vectors 00/1, 01/1, 10/1, 11/0, one per cycle -> done=1 one cycle after the 4th accept, with vec_cnt=4, err_cnt=0, pass=1, coverage=1111.
- Faulty gate: third vector 11 with y=1 -> err_cnt=1, first_fail_idx=2, first_fail_vec=3'b111, pass=0.
- in_valid=1 in IDLE -> in_ready=0 and vec_cnt stays 0. start pulsed mid-CHECK -> no restart, and vec_cnt continues from its current value.
- rst asserted after 2 accepts -> the next cycle shows state IDLE, all counters 0, done=0. A following start runs normally.
- Four vectors, all 00/1 -> with NAND_CHK_COVER_EN: coverage=0001, pass=0. Without the macro: pass=1, coverage=0000.
- ERR_W=2, NUM_VEC=6, all vectors faulty -> err_cnt=3 and held at 3, first_fail_idx=0, and done asserts after the 6th accept.
